// File: rtl/uarch_pkg.sv
// Shared microarchitecture types and sizing for the out-of-order core.
// Holds the writeback packet format and the CDB arbiter defaults.
package uarch_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    localparam int NUM_FU  = 4;
    localparam int NUM_CDB = 2;

    // Requester slot each functional unit occupies on the arbiter's request vector.
    localparam int FU_ALU = 0;
    localparam int FU_MDU = 1;
    localparam int FU_LSU = 2;
    localparam int FU_BR  = 3;

    typedef struct packed {
        logic             is_valid;
        logic             exc;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational circular-priority selector: scans requesters from rr_ptr and
// steers the first NUM_CDB valid ones onto lanes 0..NUM_CDB-1 in scan order.
module cdb_rr_picker
    import uarch_pkg::*;
#(
    parameter int NUM_FU  = uarch_pkg::NUM_FU,
    parameter int NUM_CDB = uarch_pkg::NUM_CDB,
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]  req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_FU-1:0]  gnt,
    output logic [PTR_W-1:0]   lane_idx [NUM_CDB],
    output logic [NUM_CDB-1:0] lane_vld,
    output logic [PTR_W-1:0]   last_idx,
    output logic               any_gnt
);

    always_comb begin
        int unsigned      cnt;
        logic [PTR_W-1:0] idx;
        gnt      = '0;
        lane_vld = '0;
        last_idx = '0;
        any_gnt  = 1'b0;
        cnt      = 0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            lane_idx[k] = '0;
        end
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            idx = PTR_W'((32'(rr_ptr) + i) % NUM_FU);
            if (req[idx] && cnt < NUM_CDB) begin
                gnt[idx] = 1'b1;
                // cnt counts lanes already filled, so the next winner lands in lane cnt
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (k == cnt) begin
                        lane_idx[k] = idx;
                        lane_vld[k] = 1'b1;
                    end
                end
                last_idx = idx;
                any_gnt  = 1'b1;
                cnt      = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_CDB functional-unit results per
// cycle with rotating priority and broadcasts them on registered CDB lanes.
module cdb_arbiter
    import uarch_pkg::*;
#(
    parameter int NUM_FU  = uarch_pkg::NUM_FU,
    parameter int NUM_CDB = uarch_pkg::NUM_CDB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  writeback_packet_t fu_result [NUM_FU],
    output logic [NUM_FU-1:0] fu_cdb_gnt,
    output writeback_packet_t cdb [NUM_CDB]
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_FU-1:0]  req;
    logic [NUM_FU-1:0]  pick_gnt;
    logic [PTR_W-1:0]   lane_idx [NUM_CDB];
    logic [NUM_CDB-1:0] lane_vld;
    logic [PTR_W-1:0]   last_idx;
    logic               any_gnt;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            req[i] = fu_result[i].is_valid;
        end
    end

    cdb_rr_picker #(
        .NUM_FU  (NUM_FU),
        .NUM_CDB (NUM_CDB)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .gnt      (pick_gnt),
        .lane_idx (lane_idx),
        .lane_vld (lane_vld),
        .last_idx (last_idx),
        .any_gnt  (any_gnt)
    );

    // Grant is the FU's only acceptance signal, so it must vanish under reset or flush.
    assign fu_cdb_gnt = (rst && !flush) ? pick_gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb[k] <= '0;
            end
        end else if (flush) begin
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                cdb[k] <= lane_vld[k] ? fu_result[lane_idx[k]] : '0;
            end
            if (any_gnt) begin
                rr_ptr <= (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
            end
        end
    end

endmodule
